shr_readback_capture: RTL and testbench
=======================================

Name: shr_readback_capture

Overview:
- Downstream companion to the serial shift-register driver on the DE0 board.
- Watches the driven frame (SYNC, CLK, DIN) and samples the chip's serial DOUT on each rising CLK edge inside a frame.
- Deserializes DOUT into an N_BITS capture register and checks frame length.
- Presents the captured word and status flags to the vJTAG buffer for host readback.

Parameters:
- N_BITS, 626, frame length in bits; equals the driver's data register width.
- CNT_W, 10, bit counter width; must satisfy 2^CNT_W > N_BITS.
- SYNC_STAGES, 2, synchronizer depth on the shr_* inputs; minimum 2.

Ports:
- clk_in  input  1  system clock (1 MHz PLL output).
- rst_n  input  1  asynchronous active-low reset.
- shr_clk  input  1  shift clock driven to the chip.
- shr_syn  input  1  frame sync; low means frame active.
- shr_din  input  1  serial data driven to the chip.
- shr_dout  input  1  serial data returned by the chip.
- arm  input  1  level; capture is enabled while high.
- busy  output  1  high while in SHIFT.
- cap_done  output  1  one-cycle pulse at every frame end (good or bad).
- cap_valid  output  1  cap_reg holds a complete, correct-length frame.
- frame_err  output  1  sticky; last frame was short or long.
- bit_cnt  output  CNT_W  bits sampled in the current or last frame.
- cap_reg  output  N_BITS  captured DOUT; first sampled bit at MSB.

Behaviour:
- Reset (async assert, sync release): all outputs 0, synchronizer flops 0, state IDLE.
- Inputs: shr_clk, shr_syn and shr_dout each pass through SYNC_STAGES flops.
- Edge detect on the synchronized signals:
  - clk_rise: shr_clk 0->1.
  - syn_fall: frame start.
  - syn_rise: frame end.
- IDLE:
  - On syn_fall with arm=1: go to SHIFT, clear bit_cnt, cap_valid and frame_err, set busy=1.
  - On syn_fall with arm=0: ignore the frame.
- SHIFT:
  - On each clk_rise with bit_cnt < N_BITS: cap_reg <= {cap_reg[N_BITS-2:0], dout_s}; bit_cnt++.
  - On clk_rise with bit_cnt == N_BITS: long frame. Set the overflow internal flag; cap_reg and bit_cnt stay frozen.
  - On syn_rise: go to DONE. If syn_rise and clk_rise coincide, the edge is sampled first, then the frame ends.
  - If arm falls: abort to IDLE; busy=0, no cap_done, cap_valid stays 0.
- DONE (one cycle):
  - cap_done=1, busy=0.
  - If bit_cnt == N_BITS and no overflow: cap_valid=1, frame_err=0. Otherwise cap_valid=0, frame_err=1.
  - Return to IDLE.
- Output hold:
  - cap_valid, frame_err, bit_cnt and cap_reg hold until the next armed frame start.
  - A syn_fall while in DONE is lost; the driver guarantees at least 4 idle cycles between frames.
- Latency: cap_done asserts SYNC_STAGES+2 clk_in cycles after the raw shr_syn rises.
- Zero-length frame (syn low then high, no clk edges): bit_cnt=0, frame_err=1.
- Reset mid-frame: immediate return to IDLE, all outputs cleared. The partial frame is discarded; the next syn_fall starts cleanly.

Optional Feature:
- Macro: SHR_RB_COMPARE_EN.
- With it:
  - A second N_BITS register shifts synchronized shr_din in parallel with cap_reg, clocked by the same clk_rise events.
  - On a valid frame end the DIN copy moves into wr_last.
  - Adds output port mismatch (1 bit, reset 0). In DONE, mismatch = cap_valid && wr_last_prev_valid && (cap_reg != wr_last_prev).
  - This checks that the chip returns exactly what the previous frame loaded.
  - wr_last_prev_valid clears on reset and on any frame_err.
- Without it: no DIN register, no mismatch port; shr_din is unused.

Decomposition:
- Package shr_rb_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - localparams for default N_BITS and CNT_W;
  - sync-low SYNC polarity constant.
- Sub-module shr_sync_edge: one SYNC_STAGES synchronizer plus rise/fall detector, instantiated three times (clk, syn, dout; dout uses only the level).

Test Plan:
- Nominal frame: arm=1, 626 clk edges, DOUT = alternating 1,0,... starting at 1 -> cap_done pulse, cap_valid=1, frame_err=0, bit_cnt=626, cap_reg=626'h2AA..A (MSB=1).
- Short frame: 600 edges then SYNC high -> cap_valid=0, frame_err=1, bit_cnt=600, cap_done pulses once.
- Long frame: 630 edges -> bit_cnt=626, frame_err=1, cap_reg equals the first 626 bits.
- Disarmed and abort:
  - arm=0 for a full frame -> no busy, no cap_done, prior outputs unchanged.
  - arm dropped at bit 100 -> IDLE, no cap_done.
- Async reset: rst_n low at bit 300 -> all outputs 0 within the same cycle. The next full 626-bit frame captures correctly.
- SHR_RB_COMPARE_EN: frame A writes 626'h1 (DOUT don't-care), then frame B returns DOUT = 626'h1 -> mismatch=0. Repeat with DOUT bit 0 flipped -> mismatch=1.

Source files
------------

// File: rtl/shr_rb_pkg.sv
// ============================================================================
// Module : shr_rb_pkg
// Brief  : Shared types and constants for the shift-register readback capture.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shr_rb_pkg;

  localparam int   c_n_bits_def      = 626;
  localparam int   c_cnt_w_def       = 10;
  localparam int   c_sync_stages_def = 2;

  // SYNC is driven low for the duration of a frame.
  localparam logic c_syn_active      = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shr_sync_edge.sv
// ============================================================================
// Module : shr_sync_edge
// Brief  : Multi-stage synchronizer with rise/fall detection on the output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shr_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign level = r_sync[STAGES-1];
  assign rise  = level & ~r_prev;
  assign fall  = ~level & r_prev;

endmodule

`default_nettype wire

// File: rtl/shr_readback_capture.sv
// ============================================================================
// Module : shr_readback_capture
// Brief  : Samples chip DOUT on each in-frame shift clock rise, checks frame
//          length and presents the captured word for host readback.
//          Optional macro SHR_RB_COMPARE_EN adds a DIN copy and mismatch flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shr_readback_capture
  import shr_rb_pkg::*;
#(
  parameter int N_BITS      = c_n_bits_def,
  parameter int CNT_W       = c_cnt_w_def,
  parameter int SYNC_STAGES = c_sync_stages_def
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              shr_clk,
  input  logic              shr_syn,
  input  logic              shr_din,
  input  logic              shr_dout,
  input  logic              arm,
  output logic              busy,
  output logic              cap_done,
  output logic              cap_valid,
  output logic              frame_err,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic [N_BITS-1:0] cap_reg
`ifdef SHR_RB_COMPARE_EN
  ,
  output logic              mismatch
`endif
);

  logic   w_clk_rise;
  logic   w_syn_s;
  logic   w_syn_rise;
  logic   w_syn_fall;
  logic   w_dout_s;
  logic   w_unused_clk_lvl;
  logic   w_unused_clk_fall;
  logic   w_unused_dout_rise;
  logic   w_unused_dout_fall;
  logic   w_unused_syn_lvl;

  logic   w_frame_start;
  logic   w_frame_end;
  logic   w_start;
  logic   w_sample;
  logic   w_full;
  logic   w_good;
  logic   r_overflow;

  state_t r_state;
  state_t w_state_nxt;

  shr_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk   (clk_in),
    .rst_n (rst_n),
    .d     (shr_clk),
    .level (w_unused_clk_lvl),
    .rise  (w_clk_rise),
    .fall  (w_unused_clk_fall)
  );

  shr_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_syn (
    .clk   (clk_in),
    .rst_n (rst_n),
    .d     (shr_syn),
    .level (w_syn_s),
    .rise  (w_syn_rise),
    .fall  (w_syn_fall)
  );

  shr_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dout (
    .clk   (clk_in),
    .rst_n (rst_n),
    .d     (shr_dout),
    .level (w_dout_s),
    .rise  (w_unused_dout_rise),
    .fall  (w_unused_dout_fall)
  );

  assign w_unused_syn_lvl = w_syn_s;

  // Frame boundaries follow the SYNC active level.
  assign w_frame_start = (c_syn_active == 1'b0) ? w_syn_fall : w_syn_rise;
  assign w_frame_end   = (c_syn_active == 1'b0) ? w_syn_rise : w_syn_fall;

  assign w_start  = (r_state == IDLE) && w_frame_start && arm;
  assign w_sample = (r_state == SHIFT) && arm && w_clk_rise;
  assign w_full   = (bit_cnt == CNT_W'(N_BITS));
  assign w_good   = w_full && !r_overflow;
  assign busy     = (r_state == SHIFT);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Dropping arm aborts even if the frame end arrives in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = SHIFT;
      SHIFT: begin
        if (!arm)             w_state_nxt = IDLE;
        else if (w_frame_end) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cap_done   <= 1'b0;
      cap_valid  <= 1'b0;
      frame_err  <= 1'b0;
      bit_cnt    <= '0;
      cap_reg    <= '0;
      r_overflow <= 1'b0;
    end else begin
      cap_done <= 1'b0;
      if (w_start) begin
        bit_cnt    <= '0;
        cap_valid  <= 1'b0;
        frame_err  <= 1'b0;
        r_overflow <= 1'b0;
      end
      // Extra edges beyond N_BITS freeze the capture and mark the frame long.
      if (w_sample) begin
        if (!w_full) begin
          cap_reg <= {cap_reg[N_BITS-2:0], w_dout_s};
          bit_cnt <= bit_cnt + CNT_W'(1);
        end else begin
          r_overflow <= 1'b1;
        end
      end
      if (r_state == DONE) begin
        cap_done  <= 1'b1;
        cap_valid <= w_good;
        frame_err <= !w_good;
      end
    end
  end

`ifdef SHR_RB_COMPARE_EN
  logic              w_din_s;
  logic              w_unused_din_rise;
  logic              w_unused_din_fall;
  logic [N_BITS-1:0] r_din_reg;
  logic [N_BITS-1:0] r_wr_last;
  logic              r_wr_valid;

  shr_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_din (
    .clk   (clk_in),
    .rst_n (rst_n),
    .d     (shr_din),
    .level (w_din_s),
    .rise  (w_unused_din_rise),
    .fall  (w_unused_din_fall)
  );

  // Readback of this frame is compared with what the previous frame loaded.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_din_reg  <= '0;
      r_wr_last  <= '0;
      r_wr_valid <= 1'b0;
      mismatch   <= 1'b0;
    end else begin
      if (w_start) begin
        mismatch <= 1'b0;
      end
      if (w_sample && !w_full) begin
        r_din_reg <= {r_din_reg[N_BITS-2:0], w_din_s};
      end
      if (r_state == DONE) begin
        mismatch <= w_good && r_wr_valid && (cap_reg != r_wr_last);
        if (w_good) begin
          r_wr_last  <= r_din_reg;
          r_wr_valid <= 1'b1;
        end else begin
          r_wr_valid <= 1'b0;
        end
      end
    end
  end
`else
  logic w_unused_din;
  assign w_unused_din = shr_din;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shr_readback_capture.sv
// ============================================================================
// Module : tb_shr_readback_capture
// Brief  : Self-checking bench for shr_readback_capture (scoreboard of frames).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shr_readback_capture;

  localparam int N  = 626;
  localparam int CW = 10;
  localparam int SS = 2;

  logic          clk_in   = 1'b0;
  logic          rst_n    = 1'b0;
  logic          shr_clk  = 1'b0;
  logic          shr_syn  = 1'b1;
  logic          shr_din  = 1'b0;
  logic          shr_dout = 1'b0;
  logic          arm      = 1'b0;
  logic          busy;
  logic          cap_done;
  logic          cap_valid;
  logic          frame_err;
  logic [CW-1:0] bit_cnt;
  logic [N-1:0]  cap_reg;
`ifdef SHR_RB_COMPARE_EN
  logic          mismatch;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  typedef struct {
    logic          valid;
    logic          err;
    logic [CW-1:0] cnt;
    logic [N-1:0]  cap;
    logic          mism;
  } exp_t;

  exp_t q[$];
  exp_t m_last;

  logic         m_armed    = 1'b0;
  int           m_cnt      = 0;
  logic         m_ovf      = 1'b0;
  logic [N-1:0] m_cap      = '0;
  logic [N-1:0] m_din      = '0;
  logic [N-1:0] m_wr_last  = '0;
  logic         m_wr_valid = 1'b0;

  always #5 clk_in = ~clk_in;

  shr_readback_capture #(.N_BITS(N), .CNT_W(CW), .SYNC_STAGES(SS)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .shr_clk   (shr_clk),
    .shr_syn   (shr_syn),
    .shr_din   (shr_din),
    .shr_dout  (shr_dout),
    .arm       (arm),
    .busy      (busy),
    .cap_done  (cap_done),
    .cap_valid (cap_valid),
    .frame_err (frame_err),
    .bit_cnt   (bit_cnt),
    .cap_reg   (cap_reg)
`ifdef SHR_RB_COMPARE_EN
    ,
    .mismatch  (mismatch)
`endif
  );

  // Scoreboard: every cap_done pops one expected frame result.
  always @(negedge clk_in) begin
    exp_t e;
    if (cap_done) begin
      n_done++;
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_cap_done: got cap_done=1 required 0 at %0t", $time);
      end else begin
        e = q.pop_front();
        n_checks++;
        if (cap_valid !== e.valid) begin
          n_fail++;
          $display("FAIL sb_cap_valid: got %b required %b", cap_valid, e.valid);
        end
        n_checks++;
        if (frame_err !== e.err) begin
          n_fail++;
          $display("FAIL sb_frame_err: got %b required %b", frame_err, e.err);
        end
        n_checks++;
        if (bit_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL sb_bit_cnt: got %0d required %0d", bit_cnt, e.cnt);
        end
        n_checks++;
        if (cap_reg !== e.cap) begin
          n_fail++;
          $display("FAIL sb_cap_reg: got %h required %h", cap_reg, e.cap);
        end
`ifdef SHR_RB_COMPARE_EN
        n_checks++;
        if (mismatch !== e.mism) begin
          n_fail++;
          $display("FAIL sb_mismatch: got %b required %b", mismatch, e.mism);
        end
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic drive_bit(input logic b, input logic d);
    shr_clk  = 1'b0;
    shr_dout = b;
    shr_din  = d;
    tick(2);
    shr_clk = 1'b1;
    tick(2);
    if (m_armed) begin
      if (m_cnt < N) begin
        m_cap = {m_cap[N-2:0], b};
        m_din = {m_din[N-2:0], d};
        m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic start_frame();
    shr_syn = 1'b0;
    tick(4);
    m_armed = arm;
    if (arm) begin
      m_cnt        = 0;
      m_ovf        = 1'b0;
      m_last.valid = 1'b0;
      m_last.err   = 1'b0;
      m_last.cnt   = '0;
    end
  endtask

  task automatic end_frame();
    exp_t e;
    logic good;
    shr_syn = 1'b1;
    if (m_armed) begin
      good    = (m_cnt == N) && !m_ovf;
      e.valid = good;
      e.err   = !good;
      e.cnt   = CW'(m_cnt);
      e.cap   = m_cap;
      e.mism  = good && m_wr_valid && (m_cap != m_wr_last);
      if (good) begin
        m_wr_last  = m_din;
        m_wr_valid = 1'b1;
      end else begin
        m_wr_valid = 1'b0;
      end
      q.push_back(e);
      m_last = e;
    end
    m_armed = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_checks++;
    if ({busy, cap_done, cap_valid, frame_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0000", {busy, cap_done, cap_valid, frame_err});
    end
    n_checks++;
    if (bit_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_bit_cnt: got %0d required 0", bit_cnt);
    end
    n_checks++;
    if (cap_reg !== '0) begin
      n_fail++;
      $display("FAIL reset_cap_reg: got %h required 0", cap_reg);
    end
    rst_n = 1'b1;
    tick(6);
    m_last = '{1'b0, 1'b0, '0, '0, 1'b0};
  endtask

  task automatic test_nominal();
    logic [N-1:0] alt;
    int lat;
    for (int i = 0; i < N; i++) alt[N-1-i] = (i % 2 == 0);
    arm = 1'b1;
    start_frame();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal_busy: got %b required 1", busy);
    end
    for (int i = 0; i < N; i++) drive_bit((i % 2 == 0), 1'b0);
    end_frame();
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (cap_done) begin
        lat = c;
        break;
      end
    end
    n_checks++;
    if (lat != SS + 2) begin
      n_fail++;
      $display("FAIL nominal_latency: got %0d required %0d", lat, SS + 2);
    end
    tick(4);
    n_checks++;
    if (cap_reg !== alt || bit_cnt !== CW'(N) || cap_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_result: got cnt=%0d valid=%b busy=%b reg=%h required cnt=626 valid=1 busy=0 reg=%h",
               bit_cnt, cap_valid, busy, cap_reg, alt);
    end
    tick(4);
  endtask

  task automatic test_length(input int n_edges);
    int d0;
    d0 = n_done;
    arm = 1'b1;
    start_frame();
    for (int i = 0; i < n_edges; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
    end_frame();
    tick(12);
    n_checks++;
    if (n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL len%0d_done_count: got %0d required 1", n_edges, n_done - d0);
    end
    n_checks++;
    if (frame_err !== 1'b1 || cap_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL len%0d_flags: got err=%b valid=%b required err=1 valid=0", n_edges, frame_err, cap_valid);
    end
    n_checks++;
    if (bit_cnt !== CW'((n_edges > N) ? N : n_edges)) begin
      n_fail++;
      $display("FAIL len%0d_bit_cnt: got %0d required %0d", n_edges, bit_cnt, (n_edges > N) ? N : n_edges);
    end
  endtask

  task automatic test_disarmed();
    int d0;
    d0 = n_done;
    arm = 1'b0;
    start_frame();
    for (int i = 0; i < N; i++) begin
      drive_bit(1'($urandom_range(0, 1)), 1'b0);
      if (i == N / 2) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL disarmed_busy: got %b required 0", busy);
        end
      end
    end
    end_frame();
    tick(12);
    n_checks++;
    if (n_done != d0) begin
      n_fail++;
      $display("FAIL disarmed_done: got %0d pulses required 0", n_done - d0);
    end
    n_checks++;
    if (cap_valid !== m_last.valid || frame_err !== m_last.err || bit_cnt !== m_last.cnt || cap_reg !== m_last.cap) begin
      n_fail++;
      $display("FAIL disarmed_hold: got v=%b e=%b cnt=%0d required v=%b e=%b cnt=%0d",
               cap_valid, frame_err, bit_cnt, m_last.valid, m_last.err, m_last.cnt);
    end
  endtask

  task automatic test_abort();
    int d0;
    d0 = n_done;
    arm = 1'b1;
    start_frame();
    for (int i = 0; i < 100; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
    arm     = 1'b0;
    m_armed = 1'b0;
    tick(4);
    n_checks++;
    if (busy !== 1'b0 || cap_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: got busy=%b valid=%b required 0 0", busy, cap_valid);
    end
    end_frame();
    tick(12);
    n_checks++;
    if (n_done != d0) begin
      n_fail++;
      $display("FAIL abort_done: got %0d pulses required 0", n_done - d0);
    end
    arm = 1'b1;
  endtask

  task automatic test_reset_mid();
    arm = 1'b1;
    start_frame();
    for (int i = 0; i < 300; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, cap_done, cap_valid, frame_err} !== 4'b0000 || bit_cnt !== '0 || cap_reg !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: got flags=%b cnt=%0d reg=%h required all 0",
               {busy, cap_done, cap_valid, frame_err}, bit_cnt, cap_reg);
    end
    m_armed    = 1'b0;
    m_cap      = '0;
    m_din      = '0;
    m_cnt      = 0;
    m_wr_valid = 1'b0;
    shr_syn    = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    start_frame();
    for (int i = 0; i < N; i++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
    end_frame();
    tick(12);
    n_checks++;
    if (cap_valid !== 1'b1 || bit_cnt !== CW'(N)) begin
      n_fail++;
      $display("FAIL midreset_next: got valid=%b cnt=%0d required 1 626", cap_valid, bit_cnt);
    end
  endtask

`ifdef SHR_RB_COMPARE_EN
  task automatic cmp_frame(input int kind);
    arm = 1'b1;
    start_frame();
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       drive_bit(1'($urandom_range(0, 1)), (i == N - 1));
        1:       drive_bit((i == N - 1), (i == N - 1));
        default: drive_bit(1'b0, (i == N - 1));
      endcase
    end
    end_frame();
    tick(12);
  endtask

  task automatic test_compare();
    cmp_frame(0);
    cmp_frame(1);
    n_checks++;
    if (mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL compare_match: got %b required 0", mismatch);
    end
    cmp_frame(2);
    n_checks++;
    if (mismatch !== 1'b1) begin
      n_fail++;
      $display("FAIL compare_flip: got %b required 1", mismatch);
    end
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_nominal();
    test_length(600);
    test_length(630);
    test_length(0);
    test_disarmed();
    test_abort();
    test_reset_mid();
`ifdef SHR_RB_COMPARE_EN
    test_compare();
`endif
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
